cprv_lsu: RTL and testbench

CPRV_LSU -- requirements
Module: cprv_lsu

---
 rtl/cprv_pkg.sv | 26 ++
 rtl/cprv_lsu_align.sv | 52 +++++
 rtl/cprv_lsu.sv | 193 +++++++++++++++++++
 tb/tb_cprv_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cprv_pkg.sv
// Shared constants and types for the load/store unit.
// Latency: none, declarations only.
// Backpressure: not applicable.
package cprv_pkg;

    // Major opcodes handled by the LSU
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3[1:0] access size encodings
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Unsigned doubleword load has no meaning on a 64-bit datapath
    localparam logic [2:0] F3_LDU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/cprv_lsu_align.sv
// Byte-lane steering: store strobe/data shift and load extract/extend.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module cprv_lsu_align
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [7:0]            wstrb_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] ldata_o
);

    logic [5:0]            shamt;
    logic [7:0]            size_mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  zext;

    // Shift into/out of the addressed lane, then size-mask and extend
    always_comb begin
        shamt     = {offset_i, 3'b000};
        zext      = funct3_i[2];
        wdata_o   = store_data_i << shamt;
        shifted   = rdata_i >> shamt;
        size_mask = 8'h00;
        ldata_o   = '0;
        case (funct3_i[1:0])
            SZ_B: begin
                size_mask = 8'h01;
                ldata_o   = {{(DATA_WIDTH-8){~zext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                size_mask = 8'h03;
                ldata_o   = {{(DATA_WIDTH-16){~zext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                size_mask = 8'h0F;
                ldata_o   = {{(DATA_WIDTH-32){~zext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                size_mask = 8'hFF;
                ldata_o   = shifted;
            end
        endcase
        wstrb_o = size_mask << offset_i;
    end

endmodule

// File: rtl/cprv_lsu.sv
// Load/store unit: one outstanding LOAD/STORE from execute to a 64-bit memory port.
// Latency: store accept->resp_valid 2 cycles, load 3 cycles, error 1 cycle (minimums).
// Backpressure: req_ready only in IDLE; holds mem_req until mem_gnt, resp_valid until resp_ready.
module cprv_lsu
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 64,
    parameter int OPCODE_WIDTH  = 7,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int REGADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OPCODE_WIDTH-1:0]  opcode,
    input  logic [FUNCT3_WIDTH-1:0]  funct3,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    input  logic [REGADDR_WIDTH-1:0] rd,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [7:0]               mem_wstrb,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_we,
    output logic [REGADDR_WIDTH-1:0] resp_rd,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err
);

    lsu_state_t state_q, state_d;

    logic [2:0]               funct3_q;
    logic [2:0]               offset_q;
    logic                     is_store_q;
    logic                     mem_we_q;
    logic [ADDR_WIDTH-1:0]    mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic [7:0]               mem_wstrb_q;
    logic                     resp_we_q;
    logic [REGADDR_WIDTH-1:0] resp_rd_q;
    logic [DATA_WIDTH-1:0]    resp_data_q;
    logic                     resp_err_q;

    logic                     is_load;
    logic                     is_store;
    logic                     illegal;
    logic                     misaligned;
    logic                     req_err;
    logic                     accept;

    logic [2:0]               al_funct3;
    logic [2:0]               al_offset;
    logic [7:0]               al_wstrb;
    logic [DATA_WIDTH-1:0]    al_wdata;
    logic [DATA_WIDTH-1:0]    al_ldata;

    // Decode the offered request and classify it as legal or faulting
    always_comb begin
        is_load  = (opcode == OPC_LOAD);
        is_store = (opcode == OPC_STORE);
        illegal  = !(is_load || is_store)
                 || (is_load  && (funct3[2:0] == F3_LDU))
                 || (is_store && funct3[2]);
        case (funct3[1:0])
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            SZ_D:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
        req_err = illegal || misaligned;
    end

    assign accept = (state_q == IDLE) && req_valid;

    // The aligner sees live inputs while accepting a store and the
    // captured request once a load is waiting for its read data.
    assign al_funct3 = (state_q == IDLE) ? funct3[2:0] : funct3_q;
    assign al_offset = (state_q == IDLE) ? addr[2:0]   : offset_q;

    cprv_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .funct3_i     (al_funct3),
        .offset_i     (al_offset),
        .store_data_i (store_data),
        .rdata_i      (mem_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .ldata_o      (al_ldata)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_err ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = is_store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request at accept and the load result on read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q    <= '0;
            offset_q    <= '0;
            is_store_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            resp_we_q   <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q    <= funct3[2:0];
                offset_q    <= addr[2:0];
                is_store_q  <= is_store;
                resp_rd_q   <= rd;
                resp_err_q  <= req_err;
                resp_we_q   <= is_load && !req_err && (rd != '0);
                resp_data_q <= '0;
                if (req_err) begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                end else begin
                    mem_we_q    <= is_store;
                    mem_addr_q  <= {addr[ADDR_WIDTH-1:3], 3'b000};
                    mem_wdata_q <= is_store ? al_wdata : '0;
                    mem_wstrb_q <= is_store ? al_wstrb : 8'h00;
                end
            end
            if ((state_q == WAIT) && mem_rvalid) begin
                resp_data_q <= al_ldata;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign resp_we   = resp_we_q;
    assign resp_rd   = resp_rd_q;
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_cprv_lsu.sv
// Self-checking bench for cprv_lsu: directed scenarios plus randomized traffic.
// Latency: checks cycle-exact handshake timing against a byte-level reference model.
// Backpressure: exercises delayed grant, delayed read data and stalled writeback.
module tb_cprv_lsu;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [63:0] resp_data;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cprv_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules: size in bytes, byte offset,
    // masked/extended value computed arithmetically.
    function automatic void model(
        input  logic [6:0]  op,
        input  logic [2:0]  f3,
        input  logic [63:0] a,
        input  logic [63:0] sd,
        input  logic [63:0] rdw,
        input  logic [4:0]  rdi,
        output bit          e_err,
        output logic [63:0] e_maddr,
        output logic [7:0]  e_strb,
        output logic [63:0] e_wd,
        output logic [63:0] e_rd,
        output bit          e_we,
        output bit          e_st,
        output bit          e_ld
    );
        int          sz;
        int          off;
        logic [63:0] m;
        logic [63:0] v;
        sz      = 1 << f3[1:0];
        off     = int'(a % 64'd8);
        e_ld    = (op == LOAD);
        e_st    = (op == STORE);
        e_err   = !(e_ld || e_st) || (e_ld && f3 == 3'd7) || (e_st && f3[2])
                || ((a % 64'(sz)) != 64'd0);
        e_maddr = a - (a % 64'd8);
        e_strb  = 8'h00;
        e_wd    = 64'd0;
        e_rd    = 64'd0;
        e_we    = 1'b0;
        if (!e_err && e_st) begin
            e_strb = 8'((1 << sz) - 1) << off;
            e_wd   = sd << (8 * off);
        end
        if (!e_err && e_ld) begin
            m = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
            v = (rdw >> (8 * off)) & m;
            if (!f3[2] && v[8*sz-1]) v = v | ~m;
            e_rd = v;
            e_we = (rdi != 5'd0);
        end
    endfunction

    // One full transaction: offer, grant after gdly cycles, read data after
    // rvdly cycles, writeback stalled rrdly cycles; bench checks every step.
    task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] sd, input logic [4:0] rdi, input logic [63:0] rdw,
                           input int gdly, input int rvdly, input int rrdly);
        bit          e_err, e_we, e_st, e_ld;
        logic [63:0] e_maddr, e_wd, e_rd;
        logic [7:0]  e_strb;
        model(op, f3, a, sd, rdw, rdi, e_err, e_maddr, e_strb, e_wd, e_rd, e_we, e_st, e_ld);
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd; rd = rdi;
        @(posedge clk); #1;
        // Disturb the request bus: captured fields must not follow it
        req_valid  = 1'b0;
        opcode     = 7'($urandom);
        funct3     = 3'($urandom);
        addr       = {$urandom, $urandom};
        store_data = {$urandom, $urandom};
        rd         = 5'($urandom);
        chk("busy_req_ready", req_ready, 0);
        if (e_err) begin
            chk("err_no_mem_req", mem_req, 0);
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                chk("mem_req", mem_req, 1);
                chk("mem_addr", mem_addr, e_maddr);
                chk("mem_we", mem_we, e_st);
                chk("req_ready_in_req", req_ready, 0);
                if (e_st) begin
                    chk("mem_wstrb", mem_wstrb, e_strb);
                    chk("mem_wdata", mem_wdata, e_wd);
                end
                if (i == gdly) begin
                    mem_gnt = 1'b1;
                end else begin
                    mem_rvalid = (i == 0);
                    mem_rdata  = {$urandom, $urandom};
                end
                @(posedge clk); #1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            if (e_ld) begin
                for (int i = 0; i <= rvdly; i++) begin
                    chk("wait_no_mem_req", mem_req, 0);
                    chk("wait_no_resp", resp_valid, 0);
                    if (i == rvdly) begin
                        mem_rvalid = 1'b1; mem_rdata = rdw;
                    end
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
                end
            end
        end
        for (int i = 0; i <= rrdly; i++) begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_err", resp_err, e_err);
            chk("resp_we", resp_we, e_we);
            chk("resp_mem_req", mem_req, 0);
            chk("resp_req_ready", req_ready, 0);
            if (e_ld && !e_err) begin
                chk("resp_data", resp_data, e_rd);
                chk("resp_rd", resp_rd, rdi);
            end
            if (i == rrdly) begin
                // A legal load offered in the release cycle must not be taken
                resp_ready = 1'b1;
                req_valid = 1'b1; opcode = LOAD; funct3 = 3'b011; addr = 64'h0; rd = 5'd1;
            end
            @(posedge clk); #1;
            resp_ready = 1'b0; req_valid = 1'b0;
        end
        chk("single_resp", resp_valid, 0);
        chk("no_accept_in_resp", mem_req, 0);
        chk("back_idle", req_ready, 1);
    endtask

    initial begin
        logic [6:0]  r_op;
        logic [2:0]  r_f3;
        logic [63:0] r_a;
        int          r_sel;

        rst = 1'b1;
        req_valid = 1'b0; opcode = '0; funct3 = '0; addr = '0; store_data = '0; rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
        #1;
        chk("rst_mem_req",    mem_req, 0);
        chk("rst_mem_we",     mem_we, 0);
        chk("rst_mem_wstrb",  mem_wstrb, 0);
        chk("rst_mem_addr",   mem_addr, 0);
        chk("rst_mem_wdata",  mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_we",    resp_we, 0);
        chk("rst_resp_err",   resp_err, 0);
        chk("rst_resp_data",  resp_data, 0);
        chk("rst_resp_rd",    resp_rd, 0);
        chk("rst_req_ready",  req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // SW at 0x1004, immediate grant
        run_txn(STORE, 3'b010, 64'h1004, 64'h11223344AABBCCDD, 5'd0, 64'd0, 0, 0, 0);
        // LD with delayed grant and stalled writeback
        run_txn(LOAD, 3'b011, 64'h4008, 64'd0, 5'd9, 64'h0123456789ABCDEF, 3, 0, 2);

        // Reset while waiting for read data, then a stale rvalid
        req_valid = 1'b1; opcode = LOAD; funct3 = 3'b011; addr = 64'h3000; rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("wait_before_rst", mem_req, 0);
        rst = 1'b1;
        #1;
        chk("arst_mem_addr",   mem_addr, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_resp_rd",    resp_rd, 0);
        chk("arst_req_ready",  req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("stale_rvalid_resp", resp_valid, 0);
        chk("stale_rvalid_data", resp_data, 0);
        chk("stale_rvalid_idle", req_ready, 1);

        // LB / LBU at 0x2003, then misaligned LH
        run_txn(LOAD, 3'b000, 64'h2003, 64'd0, 5'd5, 64'h0000000080000000, 0, 0, 0);
        run_txn(LOAD, 3'b100, 64'h2003, 64'd0, 5'd5, 64'h0000000080000000, 0, 0, 0);
        run_txn(LOAD, 3'b001, 64'h2001, 64'd0, 5'd5, 64'd0, 0, 0, 0);
        // Illegal encodings and load to x0
        run_txn(LOAD, 3'b111, 64'h2000, 64'd0, 5'd3, 64'd0, 0, 0, 0);
        run_txn(STORE, 3'b100, 64'h2000, 64'd1, 5'd0, 64'd0, 0, 0, 0);
        run_txn(LOAD, 3'b010, 64'h2004, 64'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 1, 2, 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r_sel = $urandom_range(9);
            r_op  = (r_sel == 0) ? 7'h33 : (r_sel < 5) ? LOAD : STORE;
            r_f3  = 3'($urandom);
            if (r_op == STORE && $urandom_range(4) != 0) r_f3[2] = 1'b0;
            r_a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) r_a = r_a & ~((64'd1 << r_f3[1:0]) - 64'd1);
            run_txn(r_op, r_f3, r_a, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                    $urandom_range(3), $urandom_range(3), $urandom_range(2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
